// File: rtl/nor3_bist_checker.sv
// BIST engine for a 3-input NOR gate: sweeps {a,b,c} = 000..111, samples the
// gate output after a programmable settle time and records mismatches.
module nor3_bist_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             tst_a,
   output logic             tst_b,
   output logic             tst_c,
   input  logic             tst_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [2:0]       fail_vec
);

   localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES);
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;

   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

   state_t           state_reg,      state_next;
   logic [2:0]       vec_reg,        vec_next;
   logic [SW-1:0]    settle_reg,     settle_next;
   logic [ERR_W-1:0] err_cnt_reg,    err_cnt_next;
   logic             fail_valid_reg, fail_valid_next;
   logic [2:0]       fail_vec_reg,   fail_vec_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         vec_reg        <= 3'b000;
         settle_reg     <= '0;
         err_cnt_reg    <= '0;
         fail_valid_reg <= 1'b0;
         fail_vec_reg   <= 3'b000;
      end else begin
         state_reg      <= state_next;
         vec_reg        <= vec_next;
         settle_reg     <= settle_next;
         err_cnt_reg    <= err_cnt_next;
         fail_valid_reg <= fail_valid_next;
         fail_vec_reg   <= fail_vec_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      vec_next        = vec_reg;
      settle_next     = settle_reg;
      err_cnt_next    = err_cnt_reg;
      fail_valid_next = fail_valid_reg;
      fail_vec_next   = fail_vec_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next      = APPLY;
               vec_next        = 3'b000;
               settle_next     = '0;
               err_cnt_next    = '0;
               fail_valid_next = 1'b0;
               fail_vec_next   = 3'b000;
            end
         end
         APPLY: begin
            if (settle_reg == SETTLE_LAST) begin
               // Good NOR output is 1 only for the all-zero vector
               if (tst_y != (vec_reg == 3'b000)) begin
                  if (err_cnt_reg != ERR_MAX) begin
                     err_cnt_next = err_cnt_reg + 1'b1;
                  end
                  if (!fail_valid_reg) begin
                     fail_valid_next = 1'b1;
                     fail_vec_next   = vec_reg;
                  end
               end
               if (vec_reg == 3'b111) begin
                  state_next = DONE;
               end else begin
                  vec_next    = vec_reg + 1'b1;
                  settle_next = '0;
               end
            end else begin
               settle_next = settle_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Stimulus is parked at 000 whenever no run is active
   assign {tst_a, tst_b, tst_c} = (state_reg == APPLY) ? vec_reg : 3'b000;
   assign busy       = (state_reg == APPLY);
   assign done       = (state_reg == DONE);
   assign pass       = done && (err_cnt_reg == '0);
   assign err_cnt    = err_cnt_reg;
   assign fail_valid = fail_valid_reg;
   assign fail_vec   = fail_vec_reg;

endmodule
